// File: rtl/cmp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_arbiter_pkg
// Description : Shared definitions for the compare arbiter and the MIPS
//               control blocks: operand width, FSM state encodings, the
//               registered compare-result record and a one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_arbiter_pkg;

    localparam int C_DATA_W = 32;

    // Arbiter FSM encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_CMP  = 2'd1;
    localparam logic [1:0] C_ST_RESP = 2'd2;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_result_t;

    // True when exactly one of the three result flags is set
    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage : cmp_arbiter_pkg
`default_nettype wire

// File: rtl/cmp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cmp_arbiter_if
// Description : Bundle of the two requester channels and the response
//               channel of the compare arbiter.
//               master : drives requests, consumes responses (requesters
//                        and consumer side)
//               slave  : the arbiter itself
// Ports       : req0_* / req1_* : valid/ready request with signed a, b
//               resp_*          : valid/ready response with id, gt, lt, eq
// Revision    : 1.0 - initial release
// ============================================================================
interface cmp_arbiter_if;
    import cmp_arbiter_pkg::*;

    logic                req0_valid;
    logic [C_DATA_W-1:0] req0_a;
    logic [C_DATA_W-1:0] req0_b;
    logic                req0_ready;

    logic                req1_valid;
    logic [C_DATA_W-1:0] req1_a;
    logic [C_DATA_W-1:0] req1_b;
    logic                req1_ready;

    logic                resp_valid;
    logic                resp_ready;
    logic                resp_id;
    logic                resp_gt;
    logic                resp_lt;
    logic                resp_eq;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  resp_valid, resp_id, resp_gt, resp_lt, resp_eq,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output resp_valid, resp_id, resp_gt, resp_lt, resp_eq,
        input  resp_ready
    );

endinterface : cmp_arbiter_if
`default_nettype wire

// File: rtl/cmp_arbiter_cmp.sv
`default_nettype none
// ============================================================================
// Module      : comparator_signed
// Description : Purely combinational two's-complement comparator.
// Ports       : a, b    - 32-bit signed operands
//               out_gt  - a > b
//               out_lt  - a < b
//               out_eq  - a == b
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_signed
    import cmp_arbiter_pkg::*;
(
    input  wire logic [C_DATA_W-1:0] a,
    input  wire logic [C_DATA_W-1:0] b,
    output logic                     out_gt,
    output logic                     out_lt,
    output logic                     out_eq
);

    assign out_gt = $signed(a) >  $signed(b);
    assign out_lt = $signed(a) <  $signed(b);
    assign out_eq = (a == b);

endmodule : comparator_signed
`default_nettype wire

// File: rtl/cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmp_arbiter
// Description : Shares one signed 32-bit comparator between two requesters
//               (branch unit = 0, set-less-than unit = 1) with round-robin
//               arbitration. One request in flight: IDLE -> CMP -> RESP.
// Ports       : clk   - rising-edge clock
//               reset - synchronous, active-high reset
//               bus   - cmp_arbiter_if.slave (request and response channels)
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_arbiter
    import cmp_arbiter_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    reset,
    cmp_arbiter_if.slave bus
);

    logic [1:0]          r_state;
    logic                r_last_grant;
    logic [C_DATA_W-1:0] r_a;
    logic [C_DATA_W-1:0] r_b;
    logic                r_id;
    cmp_result_t         r_res;

    logic                w_grant_any;
    logic                w_grant_id;
    logic                w_accept;
    logic                w_gt;
    logic                w_lt;
    logic                w_eq;

    // Round-robin pick: a lone requester always wins; under contention the
    // requester that was not granted last time goes first.
    always_comb begin
        w_grant_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = bus.req1_valid;
        end
    end

    // Ready is held low while reset is asserted, even if the state register
    // has not yet returned to IDLE.
    assign w_accept       = (r_state == C_ST_IDLE) && w_grant_any && !reset;
    assign bus.req0_ready = w_accept && !w_grant_id;
    assign bus.req1_ready = w_accept &&  w_grant_id;

    // Comparator sees only the latched operands, so requester inputs may
    // change freely once the handshake is done.
    comparator_signed u_cmp (
        .a      (r_a),
        .b      (r_b),
        .out_gt (w_gt),
        .out_lt (w_lt),
        .out_eq (w_eq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= C_ST_IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_res        <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_grant_id ? bus.req1_a : bus.req0_a;
                        r_b          <= w_grant_id ? bus.req1_b : bus.req0_b;
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_state      <= C_ST_CMP;
                    end
                end
                C_ST_CMP: begin
                    r_res   <= '{gt: w_gt, lt: w_lt, eq: w_eq};
                    r_state <= C_ST_RESP;
                end
                C_ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.resp_valid = (r_state == C_ST_RESP);
    assign bus.resp_id    = r_id;
    assign bus.resp_gt    = r_res.gt;
    assign bus.resp_lt    = r_res.lt;
    assign bus.resp_eq    = r_res.eq;

endmodule : cmp_arbiter
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_arbiter
// Description : Directed self-checking bench for cmp_arbiter. Inputs change
//               1 ns after the rising edge; outputs are checked a further
//               1 ns later or on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_arbiter;
    import cmp_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    cmp_arbiter_if bus ();

    cmp_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
    endtask

    // One full transaction with resp_ready=1, starting in an IDLE cycle.
    // With hold=0 the requests are withdrawn and operands scrambled right
    // after the handshake; the result must still reflect the latched values.
    task automatic transact(input string tag,
                            input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                            input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                            input logic hold, input logic exp_id,
                            input logic exp_gt, input logic exp_lt, input logic exp_eq);
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
        bus.resp_ready = 1'b1;
        #1;
        chk({tag, ".acc_ready0"}, bus.req0_ready, v0 && (exp_id == 1'b0));
        chk({tag, ".acc_ready1"}, bus.req1_ready, v1 && (exp_id == 1'b1));
        chk({tag, ".acc_valid"},  bus.resp_valid, 1'b0);
        step();
        if (!hold) begin
            bus.req0_valid = 1'b0; bus.req0_a = ~a0; bus.req0_b = a0 ^ 32'h5A5A_5A5A;
            bus.req1_valid = 1'b0; bus.req1_a = ~a1; bus.req1_b = a1 ^ 32'hA5A5_A5A5;
        end
        #1;
        chk({tag, ".cmp_ready0"}, bus.req0_ready, 1'b0);
        chk({tag, ".cmp_ready1"}, bus.req1_ready, 1'b0);
        chk({tag, ".cmp_valid"},  bus.resp_valid, 1'b0);
        step();
        chk({tag, ".resp_valid"}, bus.resp_valid, 1'b1);
        chk({tag, ".resp_id"},    bus.resp_id,    exp_id);
        chk({tag, ".resp_gt"},    bus.resp_gt,    exp_gt);
        chk({tag, ".resp_lt"},    bus.resp_lt,    exp_lt);
        chk({tag, ".resp_eq"},    bus.resp_eq,    exp_eq);
        step();
        chk({tag, ".done_valid"}, bus.resp_valid, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    // Continuous protocol checks
    always @(negedge clk) begin
        tests++;
        assert (!(bus.req0_ready && bus.req1_ready)) else begin
            fails++;
            $error("FAIL both_ready: observed 1 expected 0");
        end
        if (bus.resp_valid) begin
            tests++;
            assert (is_onehot3({bus.resp_gt, bus.resp_lt, bus.resp_eq})) else begin
                fails++;
                $error("FAIL onehot: observed %b expected one-hot",
                       {bus.resp_gt, bus.resp_lt, bus.resp_eq});
            end
        end
    end

    initial begin
        // Reset with both requesters active: no ready may escape
        reset = 1'b1;
        bus.resp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd3; bus.req1_b = 32'd4;
        step();
        step();
        chk("rst.ready0", bus.req0_ready, 1'b0);
        chk("rst.ready1", bus.req1_ready, 1'b0);
        chk("rst.valid",  bus.resp_valid, 1'b0);
        chk("rst.id",     bus.resp_id,    1'b0);
        chk("rst.gt",     bus.resp_gt,    1'b0);
        chk("rst.lt",     bus.resp_lt,    1'b0);
        chk("rst.eq",     bus.resp_eq,    1'b0);
        clear_reqs();
        reset = 1'b0;
        step();

        // Single requester 0, equal operands
        transact("eq12", 1'b1, 32'd12, 32'd12, 1'b0, 32'd0, 32'd0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b1);
        // Requester 1 alone, then requester 0 alone
        transact("r1lt", 1'b0, 32'd0, 32'd0, 1'b1, 32'd17, 32'd22, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b0);
        transact("r0gt", 1'b1, 32'd3, 32'd1, 1'b0, 32'd0, 32'd0, 1'b0,
                 1'b0, 1'b1, 1'b0, 1'b0);

        // Contention after reset: 0, 1, 0
        do_reset();
        transact("rr1", 1'b1, -32'sd3, 32'd1, 1'b1, 32'd3, -32'sd1, 1'b1,
                 1'b0, 1'b0, 1'b1, 1'b0);
        transact("rr2", 1'b1, -32'sd3, 32'd1, 1'b1, 32'd3, -32'sd1, 1'b1,
                 1'b1, 1'b1, 1'b0, 1'b0);
        transact("rr3", 1'b1, -32'sd3, 32'd1, 1'b1, 32'd3, -32'sd1, 1'b0,
                 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-pressure: result held 5 cycles with requester 1 waiting
        bus.req0_valid = 1'b1; bus.req0_a = -32'sd17; bus.req0_b = -32'sd22;
        bus.resp_ready = 1'b0;
        #1;
        chk("bp.acc_ready0", bus.req0_ready, 1'b1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd9; bus.req1_b = 32'd9;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid",  bus.resp_valid, 1'b1);
            chk("bp.id",     bus.resp_id,    1'b0);
            chk("bp.gt",     bus.resp_gt,    1'b1);
            chk("bp.ready1", bus.req1_ready, 1'b0);
            step();
        end
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b1;
        #1;
        chk("bp.last_valid", bus.resp_valid, 1'b1);
        step();
        chk("bp.drop_valid", bus.resp_valid, 1'b0);
        // Immediate acceptance here proves the FSM is back in IDLE
        transact("post_bp", 1'b0, 32'd0, 32'd0, 1'b1, 32'd5, 32'd5, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset during CMP discards the in-flight request
        bus.req0_valid = 1'b1; bus.req0_a = 32'd100; bus.req0_b = 32'd7;
        #1;
        chk("rcmp.acc_ready0", bus.req0_ready, 1'b1);
        step();
        clear_reqs();
        reset = 1'b1;
        step();
        chk("rcmp.valid", bus.resp_valid, 1'b0);
        chk("rcmp.gt",    bus.resp_gt,    1'b0);
        chk("rcmp.eq",    bus.resp_eq,    1'b0);
        reset = 1'b0;
        step();
        chk("rcmp.valid2", bus.resp_valid, 1'b0);

        // Extremes of the signed range
        transact("minmax", 1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b0);
        transact("maxmin", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'd0, 32'd0, 1'b0,
                 1'b0, 1'b1, 1'b0, 1'b0);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_cmp_arbiter
`default_nettype wire

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 32 bits, two's-complement signed.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 (branch unit) holds a compare request.
REQ-005 req0_a, req0_b  input  32 each  requester 0 signed operands.
REQ-006 req0_ready  output  1  requester 0 request accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 (set-less-than unit) holds a compare request.
REQ-008 req1_a, req1_b  input  32 each  requester 1 signed operands.
REQ-009 req1_ready  output  1  requester 1 request accepted this cycle.
REQ-010 resp_valid  output  1  result held on resp_* outputs.
REQ-011 resp_ready  input  1  consumer accepts the result.
REQ-012 resp_id  output  1  index of the requester that owns the result.
REQ-013 resp_gt, resp_lt, resp_eq  output  1 each  signed a>b, a<b, a==b.

Function
REQ-014 SHALL share one signed comparator between two requesters; at most one request is in flight.
REQ-015 FSM states: IDLE, CMP, RESP.
REQ-016 IDLE: if any reqN_valid, grant one requester; reqN_ready=1 combinationally for the granted requester only; latch its a, b, and id; next state CMP.
REQ-017 IDLE with no valid: stay IDLE, both ready=0.
REQ-018 Arbitration SHALL be round-robin: sole valid requester wins; if both valid, the requester not granted last wins; last_grant updates only on a handshake.
REQ-019 CMP: comparator evaluates latched operands; register gt/lt/eq; next state RESP; both ready=0.
REQ-020 RESP: resp_valid=1; resp_id/gt/lt/eq SHALL stay stable until resp_ready=1.
REQ-021 RESP with resp_ready=1: next state IDLE; resp_valid drops the following cycle.
REQ-022 Latency: accept at cycle T -> resp_valid at T+2; minimum 3 cycles between accepts.
REQ-023 Exactly one of resp_gt/resp_lt/resp_eq SHALL be 1 whenever resp_valid=1.
REQ-024 Comparison SHALL be signed over the full 32-bit range, including 0x80000000 vs 0x7FFFFFFF (lt).
REQ-025 Requester input changes outside its handshake cycle SHALL NOT affect an in-flight result.
REQ-026 Both ready outputs SHALL be 0 outside IDLE, and never both 1.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE from any state, discarding any in-flight request.
REQ-028 After reset, last_grant=1, so requester 0 wins the first contention.
REQ-029 After reset, resp_valid=0, resp_id=0, resp_gt=0, resp_lt=0, resp_eq=0, and both ready=0 while reset=1.

Structure
REQ-030 FSM state encodings SHALL reside in a shared package or header used by the MIPS control blocks.
REQ-031 Exactly one sub-module instance SHALL be used: comparator_signed (a, b, out_gt, out_lt, out_eq), the existing block.
REQ-032 The comparator SHALL be driven only from the latched operand registers.

Verification
REQ-033 req0 a=12, b=12 alone, resp_ready=1 -> req0_ready at T, resp_valid at T+2, id=0, eq=1.
REQ-034 req1 a=17, b=22 alone -> id=1, lt=1; then req0 a=3, b=1 -> id=0, gt=1.
REQ-035 Both valid after reset (req0 -3 vs 1, req1 3 vs -1), both held -> first response id=0 lt=1, second id=1 gt=1, third id=0 again.
REQ-036 req0 -17 vs -22, resp_ready=0 for 5 cycles -> resp_valid and gt=1 stable 5 cycles, no ready asserted; IDLE one cycle after resp_ready=1.
REQ-037 reset=1 during CMP -> next cycle IDLE, resp_valid=0; a subsequent req1 0x80000000 vs 0x7FFFFFFF -> lt=1 with id=1.
REQ-038 Throughout all scenarios: assert one-hot gt/lt/eq when resp_valid=1, and never both ready=1.
